// File: rtl/uart8_receiver_pkg.sv
// -----------------------------------------------------------------------------
// uart8_receiver_pkg
//   Shared definitions for the UART receive path. The state encodings and the
//   default data width are common to the receiver and the matching
//   transmitter, so both import them from here rather than redefining them.
//
//   Contents:
//     DATA_BITS_8  - default number of data bits per frame
//     rx_state_e   - frame state encoding (IDLE / START / DATA / STOP)
//     majority3()  - 2-of-3 vote used when majority sampling is built in
// -----------------------------------------------------------------------------
package uart8_receiver_pkg;

  localparam int DATA_BITS_8 = 8;

  typedef enum logic [1:0] {
    STATE_IDLE      = 2'd0,
    STATE_START_BIT = 2'd1,
    STATE_DATA_BITS = 2'd2,
    STATE_STOP_BIT  = 2'd3
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart8_receiver.sv
// -----------------------------------------------------------------------------
// uart8_receiver
//   Oversampling UART receiver: one start bit, DATA_BITS data bits (LSB
//   first), one stop bit, no parity. The clock runs at OVERSAMPLE x baud and
//   each bit is decided at phase OVERSAMPLE/2-1 of its bit period. A good
//   frame loads 'out' and pulses 'done'; a low stop bit pulses 'err' and
//   leaves 'out' untouched. A start edge is only accepted once the line has
//   been seen high (the 'armed' flag), so a held-low break cannot retrigger.
//
//   Parameters:
//     DATA_BITS   data bits per frame (default 8)
//     OVERSAMPLE  clk cycles per bit, power of two, >= 8 (default 16)
//
//   Ports:
//     clk    in   OVERSAMPLE x baud clock, rising edge
//     rst_n  in   synchronous active-low reset
//     en     in   enables start detection only; a running frame completes
//     in     in   serial rx line, idles high
//     out    out  last good word, held until the next good frame
//     done   out  one-cycle pulse after a good stop bit
//     busy   out  high while a frame is in progress
//     err    out  one-cycle pulse after a low stop bit (framing error)
//
//   Build option:
//     UART_RX_MAJORITY_EN  when defined, each bit is the 2-of-3 majority of
//                          three consecutive line samples instead of one.
// -----------------------------------------------------------------------------
module uart8_receiver
  import uart8_receiver_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int PHASE_W = $clog2(OVERSAMPLE);
  localparam int IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(DATA_BITS - 1);

  rx_state_e             state, state_nxt;
  logic [PHASE_W-1:0]    phase, phase_nxt;
  logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0]  shift, shift_nxt;
  logic [DATA_BITS-1:0]  out_nxt;
  logic                  done_nxt, err_nxt, busy_nxt;
  logic                  armed, armed_nxt;
  logic                  at_sample;
  logic                  sample_bit;

  // ---------------------------------------------------------------------------
  // Bit value at the sample point
  // ---------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
  // Two delayed copies of the line give three consecutive samples ending at
  // the sample point, so the decision edge (and therefore latency) is the
  // same as the single-sample build. The history idles at the line's idle
  // level.
  logic in_d1, in_d2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_d1 <= 1'b1;
      in_d2 <= 1'b1;
    end else begin
      in_d1 <= in;
      in_d2 <= in_d1;
    end
  end

  assign sample_bit = majority3(in_d2, in_d1, in);
`else
  assign sample_bit = in;
`endif

  assign at_sample = (phase == SAMPLE_PHASE);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of inferred latches.
    state_nxt   = state;
    phase_nxt   = phase + PHASE_W'(1);  // wraps naturally: OVERSAMPLE is 2^n
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    out_nxt     = out;
    armed_nxt   = armed;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    unique case (state)
      STATE_IDLE: begin
        phase_nxt = '0;
        if (in) begin
          armed_nxt = 1'b1;
        end else if (armed && en) begin
          state_nxt = STATE_START_BIT;
          armed_nxt = 1'b0;
        end
      end

      STATE_START_BIT: begin
        if (at_sample) begin
          if (sample_bit) begin
            // Line went back high before mid-bit: a glitch, not a start.
            state_nxt = STATE_IDLE;
          end else begin
            state_nxt   = STATE_DATA_BITS;
            bit_idx_nxt = '0;
          end
        end
      end

      STATE_DATA_BITS: begin
        if (at_sample) begin
          shift_nxt[bit_idx] = sample_bit;
          if (bit_idx == LAST_IDX) begin
            state_nxt = STATE_STOP_BIT;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end

      STATE_STOP_BIT: begin
        if (at_sample) begin
          state_nxt = STATE_IDLE;
          if (sample_bit) begin
            out_nxt   = shift;
            done_nxt  = 1'b1;
            // The stop bit itself proves the line is high, so an immediate
            // back-to-back start edge is accepted on the very next cycle.
            armed_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = STATE_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != STATE_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the shift register is ordinary flops, not a RAM, so it is
      // cleared with the rest; a reset mid-frame then leaves nothing behind.
      state   <= STATE_IDLE;
      phase   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      out     <= '0;
      armed   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      out     <= out_nxt;
      armed   <= armed_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart8_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart8_receiver
//   Self-checking bench for uart8_receiver (default parameters). The line is
//   driven on falling clock edges; outputs are observed on falling edges.
//   A monitor logs every done/err pulse with its cycle number and the value
//   of 'out' at that time; scenarios then compare the log against values
//   computed from the frame format: a frame whose start edge is sampled on
//   rising edge S yields its pulse on edge S + OS/2 + OS*(DB+1).
// -----------------------------------------------------------------------------
module tb_uart8_receiver;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int FRAME_CYCLES = OS * (DB + 2);
  localparam int LATENCY      = OS / 2 + OS * (DB + 1);

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          rx_line;
  logic [DB-1:0] out;
  logic          done;
  logic          busy;
  logic          err;

  uart8_receiver #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .in   (rx_line),
    .out  (out),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Pulse log
  // ---------------------------------------------------------------------------
  typedef struct {
    int            kind;   // 0 done, 1 err, 2 both at once
    int            cyc;
    logic [DB-1:0] outv;
  } ev_t;

  ev_t evq[$];

  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      ev_t e;
      e.kind = (done && err) ? 2 : (done ? 0 : 1);
      e.cyc  = cyc;
      e.outv = out;
      evq.push_back(e);
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops the oldest pulse and compares it with the expectation.
  task automatic expect_event(input string tag, input int kind, input int at_cyc,
                              input logic [DB-1:0] outv);
    check({tag, " pulse present"}, 32'(evq.size() > 0), 32'd1);
    if (evq.size() > 0) begin
      ev_t e;
      e = evq.pop_front();
      check({tag, " pulse kind"}, 32'(e.kind), 32'(kind));
      check({tag, " pulse cycle"}, 32'(e.cyc), 32'(at_cyc));
      check({tag, " out at pulse"}, 32'(e.outv), 32'(outv));
    end
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, " no further pulses"}, 32'(evq.size()), 32'd0);
    evq.delete();
  endtask

  // Drives one frame starting at the current falling edge and returns at the
  // falling edge where the next frame could begin. 's' is the rising edge that
  // samples the start bit first. glitch_at inverts the line for the single
  // rising edge S+glitch_at; en_drop_at clears en from edge S+en_drop_at on.
  task automatic drive_frame(input logic [DB-1:0] d, input logic stop_bit,
                             input int glitch_at, input int en_drop_at,
                             output int s);
    logic b;
    s = cyc + 1;
    for (int k = 0; k < DB + 2; k++) begin
      if (k == 0)          b = 1'b0;
      else if (k == DB + 1) b = stop_bit;
      else                 b = d[k-1];
      for (int j = 0; j < OS; j++) begin
        int rel;
        rel = k * OS + j;
        rx_line = (rel == glitch_at) ? ~b : b;
        if (rel == en_drop_at) en = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Table of directed frames
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DB-1:0] data;
    logic          stop_ok;
    logic          exp_done;
    logic          exp_err;
    logic [DB-1:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  initial begin
    automatic int s, s1, s2, s3;
    automatic logic [DB-1:0] model_out;
    automatic logic line_low;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A};

    // ---- reset state ----
    rst_n   = 1'b0;
    en      = 1'b1;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out",  32'(out),  32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err",  32'(err),  32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    evq.delete();

    // ---- table-driven frames ----
    for (int i = 0; i < 6; i++) begin
      drive_frame(vecs[i].data, vecs[i].stop_ok, -1, -1, s);
      rx_line = 1'b1;
      repeat (2) @(negedge clk);
      if (vecs[i].exp_done || vecs[i].exp_err)
        expect_event($sformatf("vec%0d", i), vecs[i].exp_err ? 1 : 0, s + LATENCY,
                     vecs[i].exp_out);
      check($sformatf("vec%0d out held", i), 32'(out), 32'(vecs[i].exp_out));
      expect_quiet($sformatf("vec%0d", i));
    end
    model_out = 8'h5A;

    // ---- short low glitch on an idle line: false start ----
    rx_line = 1'b0;
    s = cyc + 1;
    @(negedge clk);
    check("glitch busy at start", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    while (cyc < s + 7) @(negedge clk);
    check("glitch busy before sample", 32'(busy), 32'd1);
    @(negedge clk);
    check("glitch busy after sample", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("glitch out unchanged", 32'(out), 32'(model_out));
    expect_quiet("glitch");

    // ---- framing error followed by a held-low break ----
    drive_frame(8'h3C, 1'b0, -1, -1, s);
    repeat (100) @(negedge clk);
    expect_event("break", 1, s + LATENCY, model_out);
    check("break busy stays low", 32'(busy), 32'd0);
    check("break out unchanged", 32'(out), 32'(model_out));
    expect_quiet("break");
    rx_line = 1'b1;
    repeat (3) @(negedge clk);

    // ---- back-to-back frames ----
    drive_frame(8'h01, 1'b1, -1, -1, s1);
    drive_frame(8'hFF, 1'b1, -1, -1, s2);
    drive_frame(8'h80, 1'b1, -1, -1, s3);
    repeat (2) @(negedge clk);
    expect_event("b2b 0x01", 0, s1 + LATENCY, 8'h01);
    expect_event("b2b 0xFF", 0, s1 + FRAME_CYCLES + LATENCY, 8'hFF);
    expect_event("b2b 0x80", 0, s1 + 2 * FRAME_CYCLES + LATENCY, 8'h80);
    expect_quiet("b2b");

    // ---- reset in the middle of a frame ----
    fork
      drive_frame(8'h00, 1'b1, -1, -1, s);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset out",  32'(out),  32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset err",  32'(err),  32'd0);
      end
    join
    repeat (3) @(negedge clk);
    expect_quiet("midreset");
    drive_frame(8'h5A, 1'b1, -1, -1, s);
    repeat (2) @(negedge clk);
    expect_event("after reset 0x5A", 0, s + LATENCY, 8'h5A);
    expect_quiet("after reset");
    model_out = 8'h5A;

    // ---- en low blocks start detection ----
    en = 1'b0;
    drive_frame(8'h55, 1'b1, -1, -1, s);
    repeat (2) @(negedge clk);
    check("en low busy", 32'(busy), 32'd0);
    check("en low out", 32'(out), 32'(model_out));
    expect_quiet("en low");
    en = 1'b1;
    repeat (2) @(negedge clk);

    // ---- en dropped mid-frame does not abort ----
    drive_frame(8'h96, 1'b1, -1, 30, s);
    en = 1'b1;
    repeat (2) @(negedge clk);
    expect_event("en drop", 0, s + LATENCY, 8'h96);
    expect_quiet("en drop");
    model_out = 8'h96;

    // ---- single-cycle glitch at the bit-3 sample point of 0x00 ----
    drive_frame(8'h00, 1'b1, OS / 2 + OS * 4, -1, s);
    repeat (2) @(negedge clk);
`ifdef UART_RX_MAJORITY_EN
    model_out = 8'h00;
`else
    model_out = 8'h08;
`endif
    expect_event("bit3 glitch", 0, s + LATENCY, model_out);
    expect_quiet("bit3 glitch");

    // ---- randomized frames against the frame-level model ----
    line_low = 1'b0;
    for (int i = 0; i < 24; i++) begin
      automatic logic [DB-1:0] d = DB'($urandom_range(0, 255));
      automatic logic stop_ok = ($urandom_range(0, 4) != 0);
      automatic int   drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 150)) : -1;
      if (line_low) begin
        rx_line = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drive_frame(d, stop_ok, -1, drop, s);
      en = 1'b1;
      if (stop_ok) model_out = d;
      expect_event($sformatf("rand%0d d=0x%0h", i, d), stop_ok ? 0 : 1, s + LATENCY, model_out);
      expect_quiet($sformatf("rand%0d", i));
      line_low = ~stop_ok;
    end
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check("final out", 32'(out), 32'(model_out));
    expect_quiet("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound on the whole run so a stuck design cannot hang the simulation.
  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at time %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
